// File: rtl/ifu_pkg.sv
// Shared definitions for the hxd32 instruction fetch unit: FSM state encoding and PC step.
package ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2
    } ifu_state_t;

    localparam int unsigned IFU_PC_INC = 4;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous queue of {pc, inst} pairs between IRAM responses and idu.
// Head outputs read as zero while the queue is empty.
module ifu_fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic [XLEN-1:0]        push_pc_i,
    input  logic [XLEN-1:0]        push_inst_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [XLEN-1:0]        head_pc_o,
    output logic [XLEN-1:0]        head_inst_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [2*XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [2*XLEN-1:0] w_head;

    // flush wins over push/pop issued in the same cycle
    assign w_empty = (r_count == '0);
    assign w_push  = push_i && !flush_i;
    assign w_pop   = pop_i && !flush_i && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {push_pc_i, push_inst_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
        end
    end

    assign empty_o     = w_empty;
    assign count_o     = r_count;
    assign head_pc_o   = w_empty ? '0 : w_head[2*XLEN-1:XLEN];
    assign head_inst_o = w_empty ? '0 : w_head[XLEN-1:0];

endmodule

// File: rtl/ifu.sv
// hxd32 instruction fetch unit: owns the fetch PC, reads IRAM over req/gnt/rvalid, queues words for idu.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            pc_wr_en_i,
    input  logic [XLEN-1:0] pc_wr_data_i,
    output logic            iram_req_o,
    output logic [XLEN-1:0] iram_addr_o,
    input  logic            iram_gnt_i,
    input  logic            iram_rvalid_i,
    input  logic [XLEN-1:0] iram_rd_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = 1;
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(IFU_PC_INC);

    ifu_state_t      r_state;
    ifu_state_t      w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_discard;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nxt;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_inst;
    logic            w_unused_low_bits;

    assign w_unused_low_bits = &{1'b0, pc_wr_data_i[1:0]};
    assign w_redir_pc = {pc_wr_data_i[XLEN-1:2], 2'b00};
    assign w_rsp      = (r_state == IFU_WAIT) && iram_rvalid_i;
    assign w_push     = w_rsp && !r_discard && !pc_wr_en_i;
    assign w_pop      = !w_empty && inst_ready_i && !pc_wr_en_i;

    ifu_fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (w_push),
        .push_pc_i   (r_req_addr),
        .push_inst_i (iram_rd_data_i),
        .pop_i       (w_pop),
        .flush_i     (pc_wr_en_i),
        .empty_o     (w_empty),
        .count_o     (w_count),
        .head_pc_o   (w_head_pc),
        .head_inst_o (w_head_inst)
    );

    // Queue occupancy after this cycle; a slot is reserved for the word in flight.
    always_comb begin
        w_count_nxt = w_count;
        if (pc_wr_en_i)            w_count_nxt = '0;
        else if (w_push && !w_pop) w_count_nxt = w_count + CNT_ONE;
        else if (!w_push && w_pop) w_count_nxt = w_count - CNT_ONE;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IFU_IDLE: if (pc_wr_en_i || (w_count < DEPTH_C)) w_state_next = IFU_REQ;
            IFU_REQ:  if (iram_gnt_i) w_state_next = IFU_WAIT;
            IFU_WAIT: if (iram_rvalid_i) w_state_next = (w_count_nxt < DEPTH_C) ? IFU_REQ : IFU_IDLE;
            default:  w_state_next = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IFU_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_discard  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // a stale (discarded) request must not advance the redirected PC
            if (pc_wr_en_i)
                r_fetch_pc <= w_redir_pc;
            else if ((r_state == IFU_REQ) && iram_gnt_i && !r_discard)
                r_fetch_pc <= r_fetch_pc + PC_INC;
            if ((w_state_next == IFU_REQ) && (r_state != IFU_REQ))
                r_req_addr <= pc_wr_en_i ? w_redir_pc : r_fetch_pc;
            if (pc_wr_en_i)
                r_discard <= (r_state == IFU_REQ) || ((r_state == IFU_WAIT) && !iram_rvalid_i);
            else if (w_rsp)
                r_discard <= 1'b0;
        end
    end

    assign iram_req_o   = (r_state == IFU_REQ);
    assign iram_addr_o  = r_req_addr;
    assign inst_valid_o = !w_empty;
    assign inst_data_o  = w_head_inst;
    assign pc_o         = w_head_pc;
    assign pc_next_o    = w_empty ? '0 : (w_head_pc + PC_INC);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (inst_ready_i && w_empty && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (pc_wr_en_i && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_flush_cnt_o = r_flush_cnt;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Randomized scoreboard bench for ifu: an IRAM responder, a sequential-PC reference stream and a pop monitor.
module tb_ifu;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pc_wr_en_i = 1'b0;
    logic [31:0] pc_wr_data_i = '0;
    logic        iram_req_o;
    logic [31:0] iram_addr_o;
    logic        iram_gnt_i;
    logic        iram_rvalid_i;
    logic [31:0] iram_rd_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_data_o;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;

    always #5 clk_i = ~clk_i;

    ifu #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .pc_wr_en_i       (pc_wr_en_i),
        .pc_wr_data_i     (pc_wr_data_i),
        .iram_req_o       (iram_req_o),
        .iram_addr_o      (iram_addr_o),
        .iram_gnt_i       (iram_gnt_i),
        .iram_rvalid_i    (iram_rvalid_i),
        .iram_rd_data_i   (iram_rd_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_data_o      (inst_data_o),
        .pc_o             (pc_o),
        .pc_next_o        (pc_next_o),
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
    );

    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    logic [63:0] exp_q[$];
    logic [31:0] next_pc = RESET_PC;
    int          gnt_mode = 1;   // 0 random, 1 always, 2 never
    int          lat_mode = 1;   // 0 random 1..3, else fixed latency
    bit          pending = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gnt_log[$];
    int          stall_model = 0;
    int          flush_model = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Reference stream: after reset/redirect idu must see consecutive words from the start PC.
    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({next_pc, mem_word(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic reset_begin();
        rst_n_i = 1'b0;
        pc_wr_en_i = 1'b0;
        exp_q.delete();
        next_pc = RESET_PC;
        refill();
        stall_model = 0;
        flush_model = 0;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_wr_en_i = 1'b1;
        pc_wr_data_i = t;
        exp_q.delete();
        next_pc = {t[31:2], 2'b00};
        refill();
        $display("redirect target=%h", t);
        step();
        pc_wr_en_i = 1'b0;
        pc_wr_data_i = $urandom;
    endtask

    task automatic wait_pending(input string name);
        int n = 0;
        while (!pending && n < 50) begin
            step();
            n++;
        end
        if (!pending) timeout(name);
    endtask

    task automatic wait_gnts(input int target, input string name);
        int n = 0;
        while (gnt_log.size() < target && n < 100) begin
            step();
            n++;
        end
        if (gnt_log.size() < target) timeout(name);
    endtask

    // IRAM responder
    initial begin
        bit          p_req;
        bit          p_gnt;
        bit          g;
        logic [31:0] p_addr;
        p_req = 1'b0;
        p_gnt = 1'b0;
        p_addr = '0;
        iram_gnt_i = 1'b0;
        iram_rvalid_i = 1'b0;
        iram_rd_data_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_n_i && p_req && !p_gnt && iram_req_o) check("addr_hold", iram_addr_o, p_addr);
            iram_rvalid_i = 1'b0;
            iram_rd_data_i = $urandom;
            if (pending) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    iram_rvalid_i = 1'b1;
                    iram_rd_data_i = mem_word(pend_addr);
                    pending = 1'b0;
                end
            end
            g = (gnt_mode == 1) || ((gnt_mode == 0) && ($urandom_range(3, 0) != 0));
            iram_gnt_i = iram_req_o && !pending && g;
            if (iram_gnt_i) begin
                check("addr_align", {30'd0, iram_addr_o[1:0]}, 32'd0);
                pending = 1'b1;
                pend_addr = iram_addr_o;
                pend_cnt = (lat_mode == 0) ? int'($urandom_range(3, 1)) : lat_mode;
                gnt_log.push_back(iram_addr_o);
                $display("gnt addr=%h lat=%0d", iram_addr_o, pend_cnt);
            end
            p_req = iram_req_o;
            p_gnt = iram_gnt_i;
            p_addr = iram_addr_o;
        end
    end

    // Monitor: pops the expected stream whenever idu consumes a word
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (inst_ready_i && !inst_valid_o) stall_model++;
                if (pc_wr_en_i) begin
                    flush_model++;
                end else if (inst_valid_o && inst_ready_i) begin
                    if (exp_q.size() == 0) begin
                        timeout("scoreboard_empty");
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        $display("pop pc=%h inst=%h", pc_o, inst_data_o);
                        check("pop_pc", pc_o, e[63:32]);
                        check("pop_inst", inst_data_o, e[31:0]);
                        check("pop_pc_next", pc_next_o, e[63:32] + 32'd4);
                        refill();
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        int          base;
        int          r;
        logic [31:0] old_addr;
        logic [31:0] t;
        reset_begin();
        step(2);
        check("rst_req", {31'd0, iram_req_o}, 32'd0);
        check("rst_addr", iram_addr_o, RESET_PC);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_inst", inst_data_o, 32'd0);
        check("rst_pc_next", pc_next_o, 32'd0);
        check("rst_stall_cnt", perf_stall_cnt_o, 32'd0);
        check("rst_flush_cnt", perf_flush_cnt_o, 32'd0);

        // in-order streaming
        gnt_mode = 1;
        lat_mode = 1;
        inst_ready_i = 1'b1;
        rst_n_i = 1'b1;
        wait_gnts(3, "t1_gnts");
        if (gnt_log.size() >= 3) begin
            check("t1_addr0", gnt_log[0], 32'h0);
            check("t1_addr1", gnt_log[1], 32'h4);
            check("t1_addr2", gnt_log[2], 32'h8);
        end
        step(10);

        // backpressure: queue fills, requests stop
        inst_ready_i = 1'b0;
        step(10);
        check("t2_req_stopped", {31'd0, iram_req_o}, 32'd0);
        check("t2_valid", {31'd0, inst_valid_o}, 32'd1);
        step(3);
        check("t2_req_still_stopped", {31'd0, iram_req_o}, 32'd0);
        inst_ready_i = 1'b1;
        step(20);

        // redirect while a read is in flight
        lat_mode = 3;
        wait_pending("t3_pending");
        base = gnt_log.size();
        redirect(32'h0000_0103);
        wait_gnts(base + 1, "t3_gnt");
        if (gnt_log.size() > base) check("t3_new_addr", gnt_log[base], 32'h0000_0100);
        step(15);

        // redirect while a request waits for grant
        lat_mode = 1;
        gnt_mode = 2;
        base = 0;
        while (!iram_req_o && base < 50) begin
            step();
            base++;
        end
        if (!iram_req_o) timeout("t4_req");
        old_addr = iram_addr_o;
        base = gnt_log.size();
        redirect(32'h0000_0200);
        for (int k = 0; k < 3; k++) begin
            check("t4_req_held", {31'd0, iram_req_o}, 32'd1);
            check("t4_addr_held", iram_addr_o, old_addr);
            step();
        end
        gnt_mode = 1;
        wait_gnts(base + 2, "t4_gnts");
        if (gnt_log.size() >= base + 2) begin
            check("t4_stale_addr", gnt_log[base], old_addr);
            check("t4_new_addr", gnt_log[base + 1], 32'h0000_0200);
        end
        step(15);

        // asynchronous reset during a read, late rvalid arrives afterwards
        lat_mode = 3;
        wait_pending("t5_pending");
        reset_begin();
        #1;
        check("t5_valid", {31'd0, inst_valid_o}, 32'd0);
        check("t5_req", {31'd0, iram_req_o}, 32'd0);
        check("t5_addr", iram_addr_o, RESET_PC);
        check("t5_pc", pc_o, 32'd0);
        check("t5_inst", inst_data_o, 32'd0);
        base = gnt_log.size();
        step(2);
        rst_n_i = 1'b1;
        wait_gnts(base + 1, "t5_gnt");
        if (gnt_log.size() > base) check("t5_first_addr", gnt_log[base], RESET_PC);
        step(15);

        // counters: 5 starved cycles, 2 redirects
        gnt_mode = 2;
        inst_ready_i = 1'b0;
        reset_begin();
        step(2);
        inst_ready_i = 1'b1;
        rst_n_i = 1'b1;
        step(5);
        inst_ready_i = 1'b0;
        redirect(32'h0000_0040);
        redirect(32'h0000_0080);
`ifdef IFU_PERF_CNT_EN
        check("t6_stall_cnt", perf_stall_cnt_o, 32'd5);
        check("t6_flush_cnt", perf_flush_cnt_o, 32'd2);
`else
        check("t6_stall_cnt", perf_stall_cnt_o, 32'd0);
        check("t6_flush_cnt", perf_flush_cnt_o, 32'd0);
`endif

        // address wrap
        gnt_mode = 0;
        lat_mode = 0;
        inst_ready_i = 1'b1;
        redirect(32'hFFFF_FFF5);
        step(30);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            inst_ready_i = ($urandom_range(9, 0) < 7);
            r = $urandom_range(199, 0);
            if (r < 4) begin
                t = (r == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
                redirect(t);
            end else if (r == 4) begin
                reset_begin();
                step(2);
                rst_n_i = 1'b1;
            end else begin
                if (r == 5) lat_mode = $urandom_range(3, 0);
                step();
            end
        end
        gnt_mode = 1;
        inst_ready_i = 1'b1;
        step(20);

`ifdef IFU_PERF_CNT_EN
        check("end_stall_cnt", perf_stall_cnt_o, 32'(stall_model));
        check("end_flush_cnt", perf_flush_cnt_o, 32'(flush_model));
`else
        check("end_stall_cnt", perf_stall_cnt_o, 32'd0);
        check("end_flush_cnt", perf_flush_cnt_o, 32'd0);
`endif
        check("enough_pops", {31'd0, (pops >= 200)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
